// File: rtl/rv_pkg.sv
// Shared RV32 definitions for the memory-access stage: funct3 size/sign codes,
// FSM state encoding and the store lane helpers used by mem_stage.
package rv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Size lives in funct3[1:0] for both loads and stores.
  function automatic logic [3:0] byte_enables(input logic [2:0] funct3,
                                              input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b00:   return 4'b0001 << addr_lo;
      2'b01:   return 4'b0011 << {addr_lo[1], 1'b0};
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0]  funct3,
                                              input logic [31:0] data);
    case (funct3[1:0])
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_fmt.sv
// Load formatter: selects the byte/half lane of a bus word and sign- or
// zero-extends it according to funct3.
module mem_load_fmt
  import rv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output gets a value before the case, so no latch is inferred.
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
    data     = rdata;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  data = {24'h0, byte_sel};
      F3_LHU:  data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32 memory-access stage: req/ack data-memory port, load formatting and a
// registered writeback payload. Define MEM_MISALIGN_TRAP_EN to trap misaligned halves/words.
module mem_stage
  import rv_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_rs2_data,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_funct3,
  input  logic [4:0]  i_rd_addr,
  input  logic        i_reg_write,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_valid,
  input  logic        i_wb_ready,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_reg_write,
  output logic        o_bus_err,
  output logic        o_misaligned
);

  mem_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       funct3_q;
  logic [1:0]       addr_lo_q;
  logic             load_wr_q;
  logic [31:0]      load_data;
  logic             accept;
  logic             is_mem;
  logic             trap;

  assign o_ready = (state == ST_IDLE) && (!o_valid || i_wb_ready);
  assign accept  = i_valid && o_ready;
  assign is_mem  = i_mem_read || i_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = is_mem && is_misaligned(i_funct3, i_alu_result[1:0]);
`else
  assign trap = 1'b0;
`endif

  mem_load_fmt u_load_fmt (
    .rdata   (i_dmem_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .data    (load_data)
  );

  // NOTE: state and registered outputs use non-blocking assignments only, so
  // every branch sees the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      funct3_q     <= '0;
      addr_lo_q    <= '0;
      load_wr_q    <= 1'b0;
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_be    <= '0;
      o_dmem_wdata <= '0;
      o_valid      <= 1'b0;
      o_rd_addr    <= '0;
      o_rd_data    <= '0;
      o_reg_write  <= 1'b0;
      o_bus_err    <= 1'b0;
      o_misaligned <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            o_rd_addr <= i_rd_addr;
            if (is_mem && !trap) begin
              state        <= ST_WAIT;
              o_dmem_req   <= 1'b1;
              o_dmem_we    <= i_mem_write;
              o_dmem_addr  <= {i_alu_result[31:2], 2'b00};
              o_dmem_be    <= byte_enables(i_funct3, i_alu_result[1:0]);
              o_dmem_wdata <= store_lanes(i_funct3, i_rs2_data);
              funct3_q     <= i_funct3;
              addr_lo_q    <= i_alu_result[1:0];
              load_wr_q    <= i_reg_write && i_mem_read;
              o_valid      <= 1'b0;
              o_bus_err    <= 1'b0;
              o_misaligned <= 1'b0;
            end else begin
              // ALU pass-through, or a trapped access that never reaches the bus.
              o_valid      <= 1'b1;
              o_rd_data    <= i_alu_result;
              o_reg_write  <= i_reg_write && !is_mem;
              o_bus_err    <= 1'b0;
              o_misaligned <= trap;
            end
          end else if (o_valid && i_wb_ready) begin
            o_valid      <= 1'b0;
            o_bus_err    <= 1'b0;
            o_misaligned <= 1'b0;
          end
        end

        ST_WAIT: begin
          if (i_dmem_ack) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            o_dmem_req  <= 1'b0;
            o_valid     <= 1'b1;
            o_rd_data   <= o_dmem_we ? 32'h0 : load_data;
            o_reg_write <= load_wr_q;
          end else if (cnt == CNT_W'(BUS_TIMEOUT)) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            o_dmem_req  <= 1'b0;
            o_valid     <= 1'b1;
            o_rd_data   <= 32'h0;
            o_reg_write <= 1'b0;
            o_bus_err   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a byte-level memory reference model.
module tb_mem_stage;

  localparam int TMO = 255;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_alu_result = '0;
  logic [31:0] i_rs2_data = '0;
  logic        i_mem_read = 1'b0;
  logic        i_mem_write = 1'b0;
  logic [2:0]  i_funct3 = '0;
  logic [4:0]  i_rd_addr = '0;
  logic        i_reg_write = 1'b0;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [3:0]  o_dmem_be;
  logic [31:0] o_dmem_wdata;
  logic        i_dmem_ack = 1'b0;
  logic [31:0] i_dmem_rdata = '0;
  logic        o_valid;
  logic        i_wb_ready = 1'b1;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_reg_write;
  logic        o_bus_err;
  logic        o_misaligned;

  always #5 i_clk = ~i_clk;

  mem_stage dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_alu_result (i_alu_result),
    .i_rs2_data   (i_rs2_data),
    .i_mem_read   (i_mem_read),
    .i_mem_write  (i_mem_write),
    .i_funct3     (i_funct3),
    .i_rd_addr    (i_rd_addr),
    .i_reg_write  (i_reg_write),
    .o_dmem_req   (o_dmem_req),
    .o_dmem_we    (o_dmem_we),
    .o_dmem_addr  (o_dmem_addr),
    .o_dmem_be    (o_dmem_be),
    .o_dmem_wdata (o_dmem_wdata),
    .i_dmem_ack   (i_dmem_ack),
    .i_dmem_rdata (i_dmem_rdata),
    .o_valid      (o_valid),
    .i_wb_ready   (i_wb_ready),
    .o_rd_addr    (o_rd_addr),
    .o_rd_data    (o_rd_data),
    .o_reg_write  (o_reg_write),
    .o_bus_err    (o_bus_err),
    .o_misaligned (o_misaligned)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        rw;
    int          ack_dly;   // -1: never acknowledge
    logic [31:0] word;      // bus word returned while force_on is set
  } op_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] data;
    logic        rw;
    logic        err;
    logic        mis;
  } exp_t;

  typedef struct {
    op_t  op;
    exp_t ex;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] bus_mem [256];
  logic [31:0] ref_mem [256];
  bit          mem_ready = 1'b0;
  int          ack_delay = 0;
  int          wait_cyc = 0;
  bit          force_on = 1'b0;
  logic [31:0] force_rdata = '0;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Bus slave: acks after ack_delay request cycles and owns the bus-side memory.
  always @(negedge i_clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) bus_mem[i] = init_word(i);
      mem_ready = 1'b1;
    end
    if (o_dmem_req) begin
      if (wait_cyc == ack_delay) begin
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = force_on ? force_rdata : bus_mem[o_dmem_addr[9:2]];
        if (o_dmem_we)
          for (int k = 0; k < 4; k++)
            if (o_dmem_be[k]) bus_mem[o_dmem_addr[9:2]][8*k +: 8] = o_dmem_wdata[8*k +: 8];
      end else begin
        i_dmem_ack   = 1'b0;
        i_dmem_rdata = 32'hDEAD_BEEF;
      end
      wait_cyc++;
    end else begin
      i_dmem_ack = 1'b0;
      wait_cyc   = 0;
    end
  end

  function automatic op_t mk_op(input bit ld, input bit st, input logic [2:0] f3,
                                input logic [31:0] alu, input logic [31:0] rs2,
                                input logic [4:0] rd, input bit rw, input int dly,
                                input logic [31:0] word);
    op_t o;
    o.ld = ld; o.st = st; o.f3 = f3; o.alu = alu; o.rs2 = rs2;
    o.rd = rd; o.rw = rw; o.ack_dly = dly; o.word = word;
    return o;
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] addr, input logic [3:0] be,
                                  input logic [31:0] wdata, input logic [31:0] data,
                                  input bit rw, input bit err, input bit mis);
    exp_t e;
    e.addr = addr; e.be = be; e.wdata = wdata; e.data = data;
    e.rw = rw; e.err = err; e.mis = mis;
    return e;
  endfunction

  // Reference model: byte-lane arithmetic over ref_mem, derived from the ISA rules.
  function automatic exp_t predict(input op_t op);
    exp_t        e;
    int          a;
    int          sz;
    logic [31:0] w;
    logic [31:0] v;
    a  = int'(op.alu[1:0]);
    sz = int'(op.f3[1:0]);
    w  = ref_mem[op.alu[9:2]];
    e.mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    e.mis = (op.ld || op.st) && ((sz == 1 && (a % 2) == 1) || (sz == 2 && a != 0));
`endif
    e.err  = (op.ld || op.st) && !e.mis && (op.ack_dly < 0 || op.ack_dly > TMO);
    e.addr = op.alu & 32'hFFFF_FFFC;
    case (sz)
      0: begin
        e.be    = 4'(1 << a);
        e.wdata = (op.rs2 & 32'hFF) * 32'h0101_0101;
        v = (w >> (8 * a)) & 32'hFF;
        if (!op.f3[2] && v >= 32'd128) v = v - 32'd256;
      end
      1: begin
        e.be    = 4'(3 << (2 * (a / 2)));
        e.wdata = (op.rs2 & 32'hFFFF) * 32'h0001_0001;
        v = (w >> (16 * (a / 2))) & 32'hFFFF;
        if (!op.f3[2] && v >= 32'd32768) v = v - 32'd65536;
      end
      default: begin
        e.be    = 4'hF;
        e.wdata = op.rs2;
        v = w;
      end
    endcase
    e.data = op.ld ? v : op.alu;
    e.rw   = op.rw && !op.st && !e.mis && !e.err;
    return e;
  endfunction

  task automatic run_op(input op_t op, input exp_t ex);
    bit is_mem;
    bit seen;
    bit ok;
    int exp_lat;
    int exp_req;
    int lat;
    int req_cyc;
    int w;
    is_mem = op.ld || op.st;
    ok     = (op.ack_dly >= 0) && (op.ack_dly <= TMO);
    if (!is_mem || ex.mis) begin
      exp_lat = 1; exp_req = 0;
    end else if (ok) begin
      exp_lat = op.ack_dly + 2; exp_req = op.ack_dly + 1;
    end else begin
      exp_lat = TMO + 2; exp_req = TMO + 1;
    end

    @(negedge i_clk);
    w = 0;
    while (!o_ready && w < 50) begin
      @(negedge i_clk);
      w++;
    end
    check("ready_before_issue", 32'(o_ready), 32'd1);
    force_rdata  = op.word;
    ack_delay    = op.ack_dly;
    i_valid      = 1'b1;
    i_mem_read   = op.ld;
    i_mem_write  = op.st;
    i_funct3     = op.f3;
    i_alu_result = op.alu;
    i_rs2_data   = op.rs2;
    i_rd_addr    = op.rd;
    i_reg_write  = op.rw;
    @(posedge i_clk);
    #1;
    i_valid     = 1'b0;
    i_mem_read  = 1'b0;
    i_mem_write = 1'b0;

    lat = 0; req_cyc = 0; seen = 1'b0;
    while (!seen && lat < 400) begin
      @(negedge i_clk);
      lat++;
      if (o_dmem_req) begin
        req_cyc++;
        if (req_cyc == 1) begin
          check("dmem_we", 32'(o_dmem_we), 32'(op.st));
          check("dmem_addr", o_dmem_addr, ex.addr);
          check("dmem_be", 32'(o_dmem_be), 32'(ex.be));
          if (op.st) check("dmem_wdata", o_dmem_wdata, ex.wdata);
        end
      end
      if (o_valid) seen = 1'b1;
    end
    check("valid_seen", 32'(seen), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("req_cycles", 32'(req_cyc), 32'(exp_req));
    check("rd_addr", 32'(o_rd_addr), 32'(op.rd));
    check("reg_write", 32'(o_reg_write), 32'(ex.rw));
    check("bus_err", 32'(o_bus_err), 32'(ex.err));
    check("misaligned", 32'(o_misaligned), 32'(ex.mis));
    if (!op.st && !ex.err && !ex.mis) check("rd_data", o_rd_data, ex.data);
    if (is_mem) check("req_dropped", 32'(o_dmem_req), 32'd0);
    if (op.st && !ex.err && !ex.mis)
      for (int k = 0; k < 4; k++)
        if (ex.be[k]) ref_mem[op.alu[9:2]][8*k +: 8] = ex.wdata[8*k +: 8];
  endtask

  vec_t tbl[$];

  initial begin
    op_t         op;
    exp_t        ex;
    logic [2:0]  ld_f3 [5];
    ld_f3 = '{LB, LH, LW, LBU, LHU};
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    // Reset state.
    repeat (3) @(negedge i_clk);
    check("rst_req", 32'(o_dmem_req), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_reg_write", 32'(o_reg_write), 32'd0);
    check("rst_bus_err", 32'(o_bus_err), 32'd0);
    check("rst_misaligned", 32'(o_misaligned), 32'd0);
    check("rst_rd_data", o_rd_data, 32'd0);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("rst_ready", 32'(o_ready), 32'd1);

    // Directed vectors: {operation, expected bus request and payload}.
    tbl.push_back('{mk_op(1, 0, LB,  32'h103, 0, 5'd1, 1, 0, 32'h80FF_1234),
                    mk_exp(32'h100, 4'b1000, 0, 32'hFFFF_FF80, 1, 0, 0)});
    tbl.push_back('{mk_op(1, 0, LBU, 32'h102, 0, 5'd2, 1, 1, 32'h80FF_1234),
                    mk_exp(32'h100, 4'b0100, 0, 32'h0000_00FF, 1, 0, 0)});
    tbl.push_back('{mk_op(1, 0, LH,  32'h102, 0, 5'd3, 1, 2, 32'h80FF_1234),
                    mk_exp(32'h100, 4'b1100, 0, 32'hFFFF_80FF, 1, 0, 0)});
    tbl.push_back('{mk_op(1, 0, LHU, 32'h102, 0, 5'd4, 1, 0, 32'h80FF_1234),
                    mk_exp(32'h100, 4'b1100, 0, 32'h0000_80FF, 1, 0, 0)});
    tbl.push_back('{mk_op(1, 0, LH,  32'h100, 0, 5'd5, 1, 0, 32'h1234_7FFE),
                    mk_exp(32'h100, 4'b0011, 0, 32'h0000_7FFE, 1, 0, 0)});
    tbl.push_back('{mk_op(1, 0, LW,  32'h104, 0, 5'd6, 1, 3, 32'hCAFE_F00D),
                    mk_exp(32'h104, 4'b1111, 0, 32'hCAFE_F00D, 1, 0, 0)});
    tbl.push_back('{mk_op(0, 1, SH,  32'h202, 32'h0000_ABCD, 5'd7, 1, 0, 0),
                    mk_exp(32'h200, 4'b1100, 32'hABCD_ABCD, 0, 0, 0, 0)});
    tbl.push_back('{mk_op(0, 1, SB,  32'h201, 32'h1234_56A5, 5'd8, 0, 1, 0),
                    mk_exp(32'h200, 4'b0010, 32'hA5A5_A5A5, 0, 0, 0, 0)});
    tbl.push_back('{mk_op(0, 1, SW,  32'h204, 32'hDEAD_BEEF, 5'd9, 1, 2, 0),
                    mk_exp(32'h204, 4'b1111, 32'hDEAD_BEEF, 0, 0, 0, 0)});
    tbl.push_back('{mk_op(0, 0, 3'b000, 32'h0000_1234, 0, 5'd10, 1, 0, 0),
                    mk_exp(0, 0, 0, 32'h0000_1234, 1, 0, 0)});
    tbl.push_back('{mk_op(0, 0, 3'b010, 32'hFFFF_FFFF, 0, 5'd11, 0, 0, 0),
                    mk_exp(0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0)});
    tbl.push_back('{mk_op(1, 0, LW,  32'h108, 0, 5'd12, 1, -1, 32'h1111_2222),
                    mk_exp(32'h108, 4'b1111, 0, 0, 0, 1, 0)});
    tbl.push_back('{mk_op(1, 0, LW,  32'h10C, 0, 5'd13, 1, TMO, 32'h3333_4444),
                    mk_exp(32'h10C, 4'b1111, 0, 32'h3333_4444, 1, 0, 0)});
`ifdef MEM_MISALIGN_TRAP_EN
    tbl.push_back('{mk_op(1, 0, LW,  32'h101, 0, 5'd14, 1, 0, 32'h1122_3344),
                    mk_exp(0, 0, 0, 0, 0, 0, 1)});
    tbl.push_back('{mk_op(1, 0, LH,  32'h101, 0, 5'd15, 1, 0, 32'h1122_8344),
                    mk_exp(0, 0, 0, 0, 0, 0, 1)});
    tbl.push_back('{mk_op(0, 1, SH,  32'h203, 32'h0000_BEEF, 5'd16, 0, 0, 0),
                    mk_exp(0, 0, 0, 0, 0, 0, 1)});
`else
    tbl.push_back('{mk_op(1, 0, LW,  32'h101, 0, 5'd14, 1, 0, 32'h1122_3344),
                    mk_exp(32'h100, 4'b1111, 0, 32'h1122_3344, 1, 0, 0)});
    tbl.push_back('{mk_op(1, 0, LH,  32'h101, 0, 5'd15, 1, 0, 32'h1122_8344),
                    mk_exp(32'h100, 4'b0011, 0, 32'hFFFF_8344, 1, 0, 0)});
    tbl.push_back('{mk_op(0, 1, SH,  32'h203, 32'h0000_BEEF, 5'd16, 0, 0, 0),
                    mk_exp(32'h200, 4'b1100, 32'hBEEF_BEEF, 0, 0, 0, 0)});
`endif
    force_on = 1'b1;
    foreach (tbl[i]) run_op(tbl[i].op, tbl[i].ex);
    force_on = 1'b0;

    // Writeback back-pressure: payload held, no second accept until consumed.
    @(negedge i_clk);
    i_wb_ready   = 1'b0;
    i_valid      = 1'b1;
    i_alu_result = 32'h0000_1234;
    i_rd_addr    = 5'd3;
    i_reg_write  = 1'b1;
    #1 check("hold_ready_first", 32'(o_ready), 32'd1);
    @(posedge i_clk);
    #1 i_alu_result = 32'h0000_5678;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_data", o_rd_data, 32'h0000_1234);
      check("hold_ready", 32'(o_ready), 32'd0);
    end
    i_wb_ready = 1'b1;
    #1 check("hold_release_ready", 32'(o_ready), 32'd1);
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    @(negedge i_clk);
    check("refill_valid", 32'(o_valid), 32'd1);
    check("refill_data", o_rd_data, 32'h0000_5678);
    @(negedge i_clk);
    check("consumed_valid", 32'(o_valid), 32'd0);

    // Asynchronous reset in the middle of an outstanding access.
    @(negedge i_clk);
    ack_delay    = -1;
    i_valid      = 1'b1;
    i_mem_read   = 1'b1;
    i_funct3     = LW;
    i_alu_result = 32'h108;
    i_rd_addr    = 5'd9;
    @(posedge i_clk);
    #1;
    i_valid    = 1'b0;
    i_mem_read = 1'b0;
    repeat (3) @(negedge i_clk);
    check("wait_req_before_rst", 32'(o_dmem_req), 32'd1);
    #2 i_rst = 1'b0;
    #1;
    check("rst_drops_req", 32'(o_dmem_req), 32'd0);
    check("rst_clears_valid", 32'(o_valid), 32'd0);
    check("rst_ready_again", 32'(o_ready), 32'd1);
    @(negedge i_clk);
    i_rst     = 1'b1;
    ack_delay = 0;
    op = mk_op(1, 0, LB, 32'h103, 0, 5'd17, 1, 0, 0);
    run_op(op, predict(op));

    // Randomized traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      op.ld      = (kind == 1);
      op.st      = (kind == 2);
      op.f3      = op.ld ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      op.alu     = (kind == 0) ? $urandom : 32'($urandom_range(0, 1023));
      op.rs2     = $urandom;
      op.rd      = 5'($urandom_range(0, 31));
      op.rw      = 1'($urandom_range(0, 1));
      op.ack_dly = int'($urandom_range(0, 3));
      op.word    = '0;
      ex = predict(op);
      run_op(op, ex);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "simulation time limit reached");
  end

endmodule
